pipe_skid_buffer: RTL and testbench
===================================

# pipe_skid_buffer

Parametrised pipeline stage register with a valid/ready handshake on both sides and a two-entry skid buffer. It succeeds the fixed clear/hold stage register between processor pipeline stages. Stalls now propagate by backpressure, with no combinational path from `out_ready` to `in_ready`. The block also adds a synchronous flush for branch/hazard squashes and a saturating stall-cycle counter for performance monitoring.

## Interface
- `N`, default 32: data width in bits (N ≥ 1).
- `STALL_CNT_W`, default 16: width of the stall-cycle counter (≥ 1).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash of all buffered data.
- `in_valid`  in  1  upstream presents `in_data`.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  N  upstream data.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `out_data`  out  N  head word.
- `occupancy`  out  2  number of buffered words (0, 1, 2).
- `stall_count`  out  STALL_CNT_W  cycles with `out_valid`=1 and `out_ready`=0; saturating.

## Operation
- Storage:
  - main register M drives `out_data`;
  - skid register S catches one word when the downstream stalls.
- Handshakes:
  - input transfer = `in_valid && in_ready`;
  - output transfer = `out_valid && out_ready`.
- Registered outputs:
  - `in_ready` = (state != FULL);
  - `out_valid` = (state != EMPTY);
  - `occupancy` is 0/1/2 for EMPTY/BUSY/FULL.
- State machine (three states, evaluated when `flush`=0):
  - EMPTY: input transfer → M←`in_data`, go to BUSY; otherwise stay.
  - BUSY, input and output transfer → M←`in_data`, stay in BUSY.
  - BUSY, input transfer only → S←`in_data`, go to FULL.
  - BUSY, output transfer only → go to EMPTY.
  - BUSY, neither → hold.
  - FULL (`in_ready`=0): output transfer → M←S, go to BUSY; otherwise hold M and S.
- Flush:
  - `flush`=1 overrides all transfers: next state EMPTY, M←0, S←0;
  - an input word offered in a flush cycle is dropped;
  - a downstream transfer in a flush cycle still completes (the word was already visible).
- Stall counter:
  - increments when `out_valid`=1 and `out_ready`=0;
  - saturates at 2^STALL_CNT_W−1;
  - cleared only by `rst_n`; unaffected by `flush`.
- Ordering: words leave in arrival order; no drops or duplicates except under flush.
- `out_data` is defined only while `out_valid`=1. It reads 0 after reset or flush, until the first load.

## Timing
- Reset (`rst_n`=0, asynchronous, takes effect immediately):
  - state EMPTY, M=0, S=0;
  - `out_valid`=0, `in_ready`=1, `out_data`=0, `occupancy`=0, `stall_count`=0.
- Reset release is synchronous to the next rising `clk`; the first transfer can occur on that edge.
- Latency: a word accepted at edge k appears on `out_data` with `out_valid`=1 after edge k.
- Throughput: one word per cycle sustained while `out_ready`=1.
- `in_ready` deasserts the cycle after the skid fills. It reasserts the cycle after the downstream drains one word.
- Backpressure: `in_ready` and `out_valid` are pure register outputs, so no combinational path exists through the block.
- Reset asserted mid-operation: buffered words are discarded at once. No transfer is reported on either side while `rst_n`=0.

## Test plan
- Reset:
  - stimulus: assert `rst_n`=0 asynchronously between edges with occupancy 2;
  - response: immediately `out_valid`=0, `in_ready`=1, `occupancy`=0, `stall_count`=0, `out_data`=0.
- Streaming:
  - stimulus: `out_ready`=1, send 0x1, 0x2, 0x3 on consecutive cycles;
  - response: outputs 0x1, 0x2, 0x3 on consecutive cycles, each one cycle after its input; `occupancy` stays 1.
- Backpressure:
  - stimulus: `out_ready`=0, send 0xA then 0xB;
  - response: `occupancy`=2, `in_ready`=0, and 0xC is held upstream;
  - then raise `out_ready`: outputs are 0xA, 0xB, 0xC in order, and `in_ready` returns to 1 one cycle after 0xA leaves.
- Flush while FULL:
  - stimulus: assert `flush` with `in_valid`=1 carrying 0xD;
  - response: next cycle `occupancy`=0, `out_valid`=0, and 0xD never appears;
  - `stall_count` keeps its value.
- Stall counter saturation:
  - stimulus: `STALL_CNT_W`=3, hold `out_valid`=1 with `out_ready`=0 for 10 cycles;
  - response: `stall_count` reads 7 and stays at 7.
- Random traffic:
  - stimulus: 10k cycles of random `in_valid`/`out_ready`/`flush`;
  - response: a scoreboard confirms in-order, lossless delivery between flushes and zero transfers while `in_ready`=0.

Source files
------------

// File: rtl/pipe_skid_buffer.sv
// Valid/ready pipeline stage with a two-entry skid buffer, sync flush and a saturating stall counter.
// Latency: a word accepted on an edge is presented on out_data right after that edge.
// Backpressure: in_ready and out_valid decode only the state register, so out_ready never reaches in_ready combinationally.
module pipe_skid_buffer #(
    parameter int N           = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           out_data,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]             state_q;
    logic [1:0]             state_nxt;
    logic [N-1:0]           m_q;
    logic [N-1:0]           m_nxt;
    logic [N-1:0]           s_q;
    logic [N-1:0]           s_nxt;
    logic [STALL_CNT_W-1:0] stall_q;
    logic                   in_xfer;
    logic                   out_xfer;

    assign in_ready    = (state_q != FULL);
    assign out_valid   = (state_q != EMPTY);
    assign occupancy   = state_q;
    assign out_data    = m_q;
    assign stall_count = stall_q;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        state_nxt = state_q;
        m_nxt     = m_q;
        s_nxt     = s_q;
        if (flush) begin
            // Squash wins over any pending load; a downstream take this cycle still completes.
            state_nxt = EMPTY;
            m_nxt     = '0;
            s_nxt     = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        m_nxt     = in_data;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        m_nxt = in_data;
                    end else if (in_xfer) begin
                        s_nxt     = in_data;
                        state_nxt = FULL;
                    end else if (out_xfer) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        m_nxt     = s_q;
                        state_nxt = BUSY;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_nxt;
            m_q     <= m_nxt;
            s_q     <= s_nxt;
        end
    end

    // Performance counter survives flush; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed vector table plus reset, saturation and random-traffic sequences for pipe_skid_buffer.
module tb_pipe_skid_buffer;

    localparam int N  = 8;
    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_count;

    pipe_skid_buffer #(.N(N), .STALL_CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .occupancy   (occupancy),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         fl;
        logic         iv;
        logic [N-1:0] d;
        logic         ordy;
        logic         eov;
        logic         eir;
        logic [1:0]   eocc;
        logic         chkd;
        logic [N-1:0] ed;
        int           esc;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic fl, input logic iv, input logic [N-1:0] d, input logic ordy,
                       input logic eov, input logic eir, input logic [1:0] eocc,
                       input logic chkd, input logic [N-1:0] ed, input int esc);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.eov = eov; v.eir = eir; v.eocc = eocc; v.chkd = chkd; v.ed = ed; v.esc = esc;
        vecs.push_back(v);
    endtask

    logic [N-1:0] sb[$];
    logic         do_in;
    logic         do_out;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        //    fl iv  d      or  eov eir occ chkd ed    sc
        add(0, 1, 8'h01, 1,  1,  1,  1,  1, 8'h01, 0);   // streaming
        add(0, 1, 8'h02, 1,  1,  1,  1,  1, 8'h02, 0);
        add(0, 1, 8'h03, 1,  1,  1,  1,  1, 8'h03, 0);
        add(0, 0, 8'h00, 1,  0,  1,  0,  0, 8'h00, 0);
        add(0, 1, 8'h0A, 0,  1,  1,  1,  1, 8'h0A, 0);   // backpressure
        add(0, 1, 8'h0B, 0,  1,  0,  2,  1, 8'h0A, 1);
        add(0, 1, 8'h0C, 0,  1,  0,  2,  1, 8'h0A, 2);
        add(0, 1, 8'h0C, 1,  1,  1,  1,  1, 8'h0B, 2);
        add(0, 1, 8'h0C, 1,  1,  1,  1,  1, 8'h0C, 2);
        add(0, 0, 8'h00, 1,  0,  1,  0,  0, 8'h00, 2);
        add(0, 1, 8'h04, 0,  1,  1,  1,  1, 8'h04, 2);   // flush while FULL
        add(0, 1, 8'h05, 0,  1,  0,  2,  1, 8'h04, 3);
        add(1, 1, 8'h0D, 0,  0,  1,  0,  1, 8'h00, 4);
        add(0, 0, 8'h00, 1,  0,  1,  0,  1, 8'h00, 4);
        add(0, 1, 8'h06, 1,  1,  1,  1,  1, 8'h06, 4);
        add(1, 0, 8'h00, 1,  0,  1,  0,  1, 8'h00, 4);   // flush with downstream take

        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_occupancy", int'(occupancy), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_stall_count", int'(stall_count), 0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            flush = vecs[i].fl; in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy;
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", i), int'(out_valid), int'(vecs[i].eov));
            chk($sformatf("v%0d_in_ready", i), int'(in_ready), int'(vecs[i].eir));
            chk($sformatf("v%0d_occupancy", i), int'(occupancy), int'(vecs[i].eocc));
            chk($sformatf("v%0d_stall_count", i), int'(stall_count), vecs[i].esc);
            if (vecs[i].chkd)
                chk($sformatf("v%0d_out_data", i), int'(out_data), int'(vecs[i].ed));
        end

        // Fill to FULL, then assert reset between edges.
        flush = 1'b0; in_valid = 1'b1; in_data = 8'h07; out_ready = 1'b0;
        @(negedge clk);
        in_data = 8'h08;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_occupancy", int'(occupancy), 2);
        chk("pre_rst_stall_count", int'(stall_count), 5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_occupancy", int'(occupancy), 0);
        chk("arst_stall_count", int'(stall_count), 0);
        chk("arst_out_data", int'(out_data), 0);

        // Saturation: one word held with downstream stalled.
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 8'h09; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("sat_load_occupancy", int'(occupancy), 1);
        chk("sat_start_count", int'(stall_count), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("sat_count_%0d", i), int'(stall_count), (i + 1 > 7) ? 7 : i + 1);
        end

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;

        // Random traffic against a queue scoreboard.
        for (int c = 0; c < 10000; c++) begin
            chk("rnd_occupancy", int'(occupancy), sb.size());
            chk("rnd_in_ready", int'(in_ready), (sb.size() < 2) ? 1 : 0);
            chk("rnd_out_valid", int'(out_valid), (sb.size() > 0) ? 1 : 0);
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            flush     = ($urandom_range(0, 99) < 2);
            in_data   = N'($urandom);
            do_in  = in_valid && in_ready;
            do_out = out_valid && out_ready;
            if (do_out) begin
                if (sb.size() == 0) begin
                    chk("rnd_unexpected_out", 1, 0);
                end else begin
                    chk("rnd_out_data", int'(out_data), int'(sb[0]));
                    void'(sb.pop_front());
                end
            end
            if (flush)
                sb.delete();
            else if (do_in)
                sb.push_back(in_data);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
